bios_tx: RTL and testbench
==========================

BIOS_TX -- requirements
Module: bios_tx

Interface
REQ-001 SHALL have parameter: ECHO_BYTE, default 8'hA5, payload byte sent for ECHO responses.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: clk_en  input  1  advance enable; no state change when low.
REQ-005 SHALL have port: resp_valid  input  1  response request from bios command FSM.
REQ-006 SHALL have port: resp_ready  output  1  block can accept a response.
REQ-007 SHALL have port: resp_kind  input  2  00 ACK, 01 ECHO, 10 DATA, 11 ERROR.
REQ-008 SHALL have port: resp_size  input  2  DATA payload size: 00=1, 01=2, 10=4, 11=4 bytes.
REQ-009 SHALL have port: resp_err  input  4  error code placed in header.
REQ-010 SHALL have port: resp_data  input  32  DATA payload, sent little-endian.
REQ-011 SHALL have port: tx_valid  output  1  tx_data holds a byte for the UART transmitter.
REQ-012 SHALL have port: tx_ready  input  1  UART transmitter accepts byte.
REQ-013 SHALL have port: tx_data  output  8  outgoing byte.
REQ-014 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port: frame_count  output  8  completed frames, wraps 255->0.

Function
REQ-016 SHALL implement FSM states IDLE, HDR, PAYLOAD, CSUM.
REQ-017 SHALL drive resp_ready high only in IDLE.
REQ-018 SHALL, in IDLE when resp_valid && clk_en, capture kind/size/err/data and move to HDR on that edge.
REQ-019 SHALL form header byte as {kind[1:0], size[1:0], err[3:0]}.
REQ-020 SHALL assert tx_valid in HDR, PAYLOAD and CSUM; deassert in IDLE.
REQ-021 SHALL consider a byte transferred only on an edge with tx_valid && tx_ready && clk_en.
REQ-022 SHALL hold tx_data stable while tx_valid is high and no transfer has occurred.
REQ-023 SHALL, after header transfer: DATA -> PAYLOAD with N bytes per resp_size; ECHO -> PAYLOAD with one byte ECHO_BYTE; ACK/ERROR -> frame end.
REQ-024 SHALL send DATA bytes least-significant first, using a byte index counter reset to 0 per frame.
REQ-025 SHALL, at frame end, go to CSUM if enabled (REQ-033), else IDLE, incrementing frame_count on the final byte transfer.
REQ-026 SHALL ignore resp_* inputs while busy; captured fields are unaffected by input changes mid-frame.
REQ-027 SHALL give one IDLE cycle (resp_ready high) between consecutive frames; first byte valid one edge after acceptance.
REQ-028 SHALL hold all state, including tx_valid/tx_data, unchanged on edges with clk_en low.

Reset
REQ-029 SHALL, on rst_n low, immediately force state IDLE, tx_valid 0, tx_data 8'h00, busy 0, frame_count 0, checksum 0, byte index 0.
REQ-030 SHALL abort any frame in progress on reset without completing it or counting it.
REQ-031 SHALL drive resp_ready high while rst_n is low.
REQ-032 SHALL resume normal operation on the first enabled edge after rst_n rises.

Configuration
REQ-033 SHALL, with BIOS_TX_CHECKSUM_EN defined, append one CSUM byte equal to the XOR of all preceding bytes in the frame; frame_count increments on the CSUM transfer.
REQ-034 SHALL, without BIOS_TX_CHECKSUM_EN, omit CSUM state and checksum logic; the frame ends on the last header/payload byte.

Verification
REQ-035 SHALL cover: DATA size 10 data 32'hDEADBEEF err 0, tx_ready=1, CHECKSUM_EN -> A0,EF,BE,AD,DE,82 on 6 consecutive edges; frame_count 1.
REQ-036 SHALL cover: ECHO, CHECKSUM_EN -> 40,A5,E5; without macro -> 40,A5.
REQ-037 SHALL cover: ERROR err 4'h3 size 00 -> C3 (then C3 checksum if enabled); ACK -> 00 (then 00).
REQ-038 SHALL cover: tx_ready low 5 cycles mid-DATA -> tx_valid stays 1 and tx_data constant; no byte skipped or duplicated.
REQ-039 SHALL cover: rst_n pulsed low during PAYLOAD -> tx_valid 0 same cycle; frame_count unchanged; next frame starts from a fresh header.
REQ-040 SHALL cover: 256 ACK frames -> frame_count wraps to 0; clk_en held low 3 cycles mid-frame -> no state change.

Source files
------------

// File: rtl/bios_tx.sv
// BIOS response framer: serialises header, optional payload and optional XOR checksum
// bytes to a UART transmitter. Checksum byte is enabled by defining BIOS_TX_CHECKSUM_EN.
module bios_tx #(
  parameter logic [7:0] ECHO_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [1:0]  resp_kind,
  input  logic [1:0]  resp_size,
  input  logic [3:0]  resp_err,
  input  logic [31:0] resp_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [7:0]  frame_count
);

`ifdef BIOS_TX_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, CSUM} state_e;
`else
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_e;
`endif

  localparam logic [1:0] K_ECHO = 2'b01;
  localparam logic [1:0] K_DATA = 2'b10;

  state_e      state_q, state_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [1:0]  kind_q, kind_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
`ifdef BIOS_TX_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic       xfer;
  logic       fin;
  logic [1:0] last_idx;
  logic [1:0] nxt_idx;

  assign xfer    = tx_valid_q & tx_ready & clk_en;
  assign nxt_idx = idx_q + 2'd1;

  // ECHO carries a single byte; DATA sizes 10 and 11 both carry four
  always_comb begin
    last_idx = 2'd0;
    if (kind_q == K_DATA) begin
      case (size_q)
        2'b00:   last_idx = 2'd0;
        2'b01:   last_idx = 2'd1;
        default: last_idx = 2'd3;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    kind_d      = kind_q;
    size_d      = size_q;
    data_d      = data_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    fin         = 1'b0;
`ifdef BIOS_TX_CHECKSUM_EN
    csum_d      = csum_q;
    if (xfer) csum_d = csum_q ^ tx_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (clk_en && resp_valid) begin
          kind_d     = resp_kind;
          size_d     = resp_size;
          data_d     = resp_data;
          idx_d      = 2'd0;
`ifdef BIOS_TX_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
          tx_valid_d = 1'b1;
          tx_data_d  = {resp_kind, resp_size, resp_err};
          state_d    = HDR;
        end
      end
      HDR: begin
        if (xfer) begin
          idx_d = 2'd0;
          if (kind_q == K_DATA) begin
            tx_data_d = data_q[7:0];
            state_d   = PAYLOAD;
          end else if (kind_q == K_ECHO) begin
            tx_data_d = ECHO_BYTE;
            state_d   = PAYLOAD;
          end else begin
            fin = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          if (idx_q == last_idx) begin
            fin = 1'b1;
          end else begin
            idx_d     = nxt_idx;
            tx_data_d = data_q[{nxt_idx, 3'b000} +: 8];
          end
        end
      end
`ifdef BIOS_TX_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          state_d     = IDLE;
          tx_valid_d  = 1'b0;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (fin) begin
`ifdef BIOS_TX_CHECKSUM_EN
      state_d   = CSUM;
      tx_data_d = csum_d;
`else
      state_d     = IDLE;
      tx_valid_d  = 1'b0;
      frame_cnt_d = frame_cnt_q + 8'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      kind_q      <= 2'b00;
      size_q      <= 2'b00;
      data_q      <= 32'h0;
      idx_q       <= 2'd0;
      frame_cnt_q <= 8'h00;
`ifdef BIOS_TX_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      kind_q      <= kind_d;
      size_q      <= size_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef BIOS_TX_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign resp_ready  = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_bios_tx.sv
// Bench for bios_tx: queue-of-bytes frame model, per-cycle compare, directed literal frames
// plus a randomized phase. Honours BIOS_TX_CHECKSUM_EN for the expected byte stream.
module tb_bios_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        resp_valid = 1'b0;
  logic        resp_ready;
  logic [1:0]  resp_kind = 2'b00;
  logic [1:0]  resp_size = 2'b00;
  logic [3:0]  resp_err = 4'h0;
  logic [31:0] resp_data = 32'h0;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        busy;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] log_b[$];
  int         log_c[$];
  logic [7:0] m_count = 8'h00;

  bios_tx dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_kind(resp_kind), .resp_size(resp_size), .resp_err(resp_err), .resp_data(resp_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected byte stream of one frame, straight from the framing rules
  function automatic void push_frame(input logic [1:0] k, input logic [1:0] s,
                                     input logic [3:0] e, input logic [31:0] d);
    int n;
    logic [7:0] x;
    logic [7:0] b;
    b = {k, s, e};
    exp_q.push_back(b);
    x = b;
    n = (k == 2'b10) ? ((s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4) : (k == 2'b01) ? 1 : 0;
    for (int i = 0; i < n; i++) begin
      b = (k == 2'b01) ? 8'hA5 : d[8*i +: 8];
      exp_q.push_back(b);
      x = x ^ b;
    end
`ifdef BIOS_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_count <= 8'h00;
    end else begin
      cyc <= cyc + 1;
      if (clk_en) begin
        if (exp_q.size() == 0) begin
          if (resp_valid) push_frame(resp_kind, resp_size, resp_err, resp_data);
        end else if (tx_ready) begin
          log_b.push_back(tx_data);
          log_c.push_back(cyc);
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_count <= m_count + 8'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("tx_valid", {31'b0, tx_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("tx_data", {24'b0, tx_data}, {24'b0, exp_q[0]});
    chk("busy", {31'b0, busy}, {31'b0, exp_q.size() != 0});
    chk("resp_ready", {31'b0, resp_ready}, {31'b0, exp_q.size() == 0});
    chk("frame_count", {24'b0, frame_count}, {24'b0, m_count});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin step(); n++; end
    if (busy) chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic send(input logic [1:0] k, input logic [1:0] s,
                      input logic [3:0] e, input logic [31:0] d);
    wait_idle();
    clk_en = 1'b1;
    resp_valid = 1'b1;
    resp_kind = k; resp_size = s; resp_err = e; resp_data = d;
    step();
    resp_valid = 1'b0;
    resp_kind = 2'($urandom); resp_size = 2'($urandom);
    resp_err = 4'($urandom); resp_data = $urandom;
  endtask

  // exp holds the bytes first-to-last from the most significant end
  task automatic chk_log(input string name, input logic [63:0] exp, input int n);
    chk({name, "_len"}, log_b.size(), n);
    for (int i = 0; i < n && i < log_b.size(); i++)
      chk(name, {24'b0, log_b[i]}, {24'b0, exp[8*(n-1-i) +: 8]});
  endtask

  initial begin
    logic [7:0] d0;
    repeat (2) step();
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'h00);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_resp_ready", {31'b0, resp_ready}, 32'd1);
    chk("rst_frame_count", {24'b0, frame_count}, 32'd0);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    step();

    log_b.delete(); log_c.delete();
    send(2'b10, 2'b10, 4'h0, 32'hDEADBEEF);
    wait_idle();
`ifdef BIOS_TX_CHECKSUM_EN
    chk_log("data_frame", 64'hA0EFBEADDE82, 6);
    chk("data_consec", log_c[5] - log_c[0], 5);
`else
    chk_log("data_frame", 64'hA0EFBEADDE, 5);
    chk("data_consec", log_c[4] - log_c[0], 4);
`endif
    chk("data_fcount", {24'b0, frame_count}, 32'd1);

    log_b.delete();
    send(2'b01, 2'b00, 4'h0, 32'h0);
    wait_idle();
`ifdef BIOS_TX_CHECKSUM_EN
    chk_log("echo_frame", 64'h40A5E5, 3);
`else
    chk_log("echo_frame", 64'h40A5, 2);
`endif

    log_b.delete();
    send(2'b11, 2'b00, 4'h3, 32'h0);
    send(2'b00, 2'b00, 4'h0, 32'h0);
    wait_idle();
`ifdef BIOS_TX_CHECKSUM_EN
    chk_log("err_ack", 64'hC3C30000, 4);
`else
    chk_log("err_ack", 64'hC300, 2);
`endif
    chk("err_ack_fcount", {24'b0, frame_count}, 32'd4);

    // Backpressure mid-DATA
    log_b.delete();
    send(2'b10, 2'b11, 4'h0, 32'h12345678);
    step(); step();
    tx_ready = 1'b0;
    d0 = tx_data;
    chk("stall_byte", {24'b0, d0}, 32'h56);
    repeat (5) begin
      step();
      chk("stall_valid", {31'b0, tx_valid}, 32'd1);
      chk("stall_data", {24'b0, tx_data}, 32'h56);
    end
    tx_ready = 1'b1;
    wait_idle();
`ifdef BIOS_TX_CHECKSUM_EN
    chk_log("stall_frame", 64'hB078563412B8, 6);
`else
    chk_log("stall_frame", 64'hB078563412, 5);
`endif

    // Enable held low mid-frame
    log_b.delete();
    send(2'b01, 2'b00, 4'h0, 32'h0);
    clk_en = 1'b0;
    repeat (3) begin
      step();
      chk("hold_data", {24'b0, tx_data}, 32'h40);
      chk("hold_busy", {31'b0, busy}, 32'd1);
    end
    clk_en = 1'b1;
    wait_idle();
`ifdef BIOS_TX_CHECKSUM_EN
    chk_log("hold_frame", 64'h40A5E5, 3);
`else
    chk_log("hold_frame", 64'h40A5, 2);
`endif

    // Reset during payload
    send(2'b10, 2'b11, 4'h0, 32'hCAFEF00D);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_fcount", {24'b0, frame_count}, 32'd0);
    step();
    rst_n = 1'b1;
    log_b.delete();
    send(2'b00, 2'b00, 4'h0, 32'h0);
    wait_idle();
`ifdef BIOS_TX_CHECKSUM_EN
    chk_log("post_rst", 64'h0000, 2);
`else
    chk_log("post_rst", 64'h00, 1);
`endif
    chk("post_rst_fcount", {24'b0, frame_count}, 32'd1);

    // Counter wrap
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 0; i < 255; i++) send(2'b00, 2'b00, 4'h0, 32'h0);
    wait_idle();
    chk("wrap_255", {24'b0, frame_count}, 32'd255);
    send(2'b00, 2'b00, 4'h0, 32'h0);
    wait_idle();
    chk("wrap_0", {24'b0, frame_count}, 32'd0);

    // Randomized traffic; resp_* change every cycle, including mid-frame
    for (int i = 0; i < 4000; i++) begin
      clk_en = ($urandom_range(0, 9) != 0);
      tx_ready = ($urandom_range(0, 3) != 0);
      resp_valid = ($urandom_range(0, 2) == 0);
      resp_kind = 2'($urandom); resp_size = 2'($urandom);
      resp_err = 4'($urandom); resp_data = $urandom;
      step();
    end
    clk_en = 1'b1; tx_ready = 1'b1; resp_valid = 1'b0;
    wait_idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
